// File: rtl/edge_period_meter.sv
// Measures clock cycles between successive accepted edge pulses and presents each result on a valid/ready slot.
// Optional EDGE_PERIOD_DROP_COUNT_EN adds a saturating drop_count output alongside the sticky drop_flag.
module edge_period_meter #(
  parameter int WIDTH      = 16,
  parameter int MIN_PERIOD = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             edge_in,
  input  logic             period_ready,
  output logic             period_valid,
  output logic [WIDTH-1:0] period_data,
  output logic             period_ovf,
`ifdef EDGE_PERIOD_DROP_COUNT_EN
  output logic [7:0]       drop_count,
`endif
  output logic             drop_flag
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_P   = WIDTH'(MIN_PERIOD);

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic             ovf_pending;
  logic             slot_free;
  logic             accept;

  assign slot_free = !period_valid || period_ready;
  assign accept    = edge_in && ((counter >= MIN_P) || ovf_pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      ovf_pending  <= 1'b0;
      period_valid <= 1'b0;
      period_data  <= '0;
      period_ovf   <= 1'b0;
      drop_flag    <= 1'b0;
`ifdef EDGE_PERIOD_DROP_COUNT_EN
      drop_count   <= 8'd0;
`endif
    end else begin
      // A consumed result frees the slot; a new result this cycle overrides below.
      if (period_valid && period_ready)
        period_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (edge_in) begin
            state   <= MEASURE;
            counter <= CNT_ONE;
          end
        end
        MEASURE: begin
          if (accept) begin
            counter     <= CNT_ONE;
            ovf_pending <= 1'b0;
            if (slot_free) begin
              period_valid <= 1'b1;
              period_data  <= ovf_pending ? CNT_MAX : counter;
              period_ovf   <= ovf_pending;
            end else begin
              drop_flag <= 1'b1;
`ifdef EDGE_PERIOD_DROP_COUNT_EN
              if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
`endif
            end
          end else if (counter == CNT_MAX) begin
            // Counting past the all-ones value means the interval no longer fits.
            ovf_pending <= 1'b1;
          end else begin
            counter <= counter + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_period_meter.sv
// Directed bench for edge_period_meter: table-driven vectors on a default instance,
// plus hand-written sequences on WIDTH=4 and MIN_PERIOD=3 instances sharing the same stimulus.
module tb_edge_period_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic edge_in = 1'b0;
  logic ready = 1'b1;

  logic        d_valid, d_ovf, d_drop;
  logic [15:0] d_data;
  logic        w_valid, w_ovf, w_drop;
  logic [3:0]  w_data;
  logic        m_valid, m_ovf, m_drop;
  logic [15:0] m_data;
`ifdef EDGE_PERIOD_DROP_COUNT_EN
  logic [7:0]  d_dc, w_dc, m_dc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  edge_period_meter dut_d (
    .clk(clk), .rst(rst), .edge_in(edge_in), .period_ready(ready),
    .period_valid(d_valid), .period_data(d_data), .period_ovf(d_ovf),
`ifdef EDGE_PERIOD_DROP_COUNT_EN
    .drop_count(d_dc),
`endif
    .drop_flag(d_drop)
  );

  edge_period_meter #(.WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .edge_in(edge_in), .period_ready(ready),
    .period_valid(w_valid), .period_data(w_data), .period_ovf(w_ovf),
`ifdef EDGE_PERIOD_DROP_COUNT_EN
    .drop_count(w_dc),
`endif
    .drop_flag(w_drop)
  );

  edge_period_meter #(.MIN_PERIOD(3)) dut_m (
    .clk(clk), .rst(rst), .edge_in(edge_in), .period_ready(ready),
    .period_valid(m_valid), .period_data(m_data), .period_ovf(m_ovf),
`ifdef EDGE_PERIOD_DROP_COUNT_EN
    .drop_count(m_dc),
`endif
    .drop_flag(m_drop)
  );

  typedef struct {
    logic        e;
    logic        r;
    logic        rs;
    logic        v;
    logic [15:0] d;
    logic        o;
    logic        dr;
    logic [7:0]  dc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic r, input logic rs, input logic v,
                     input logic [15:0] d, input logic o, input logic dr, input logic [7:0] dc);
    vec_t t;
    t.e = e; t.r = r; t.rs = rs; t.v = v; t.d = d; t.o = o; t.dr = dr; t.dc = dc;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply inputs, clock once, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic r, input logic rs);
    edge_in = e;
    ready   = r;
    rst     = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    add(0,1,1, 0,0,0,0,0);
    add(0,1,1, 0,0,0,0,0);
    // four consecutive edges -> three results of 1
    add(1,1,0, 0,0,0,0,0);
    add(1,1,0, 1,1,0,0,0);
    add(1,1,0, 1,1,0,0,0);
    add(1,1,0, 1,1,0,0,0);
    add(0,1,0, 0,1,0,0,0);
    add(0,1,1, 0,0,0,0,0);
    // backpressure: edges every 5 cycles with ready low
    add(1,0,0, 0,0,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0, 0,0,0,0,0);
    add(1,0,0, 1,5,0,0,0);
    for (int i = 0; i < 4; i++) add(0,0,0, 1,5,0,0,0);
    add(1,0,0, 1,5,0,1,1);
    for (int i = 0; i < 4; i++) add(0,0,0, 1,5,0,1,1);
    add(1,0,0, 1,5,0,1,2);
    add(0,1,0, 0,5,0,1,2);
    add(0,1,1, 0,0,0,0,0);
    // reset aborts an open interval; the next edge only opens a new one
    add(1,1,0, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(0,1,1, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(1,1,0, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(0,1,0, 0,0,0,0,0);
    add(1,1,0, 1,3,0,0,0);
    add(0,1,0, 0,3,0,0,0);

    foreach (vecs[i]) begin
      step(vecs[i].e, vecs[i].r, vecs[i].rs);
      check($sformatf("vec%0d valid", i), {31'd0, d_valid}, {31'd0, vecs[i].v});
      check($sformatf("vec%0d data", i), {16'd0, d_data}, {16'd0, vecs[i].d});
      check($sformatf("vec%0d ovf", i), {31'd0, d_ovf}, {31'd0, vecs[i].o});
      check($sformatf("vec%0d drop", i), {31'd0, d_drop}, {31'd0, vecs[i].dr});
`ifdef EDGE_PERIOD_DROP_COUNT_EN
      check($sformatf("vec%0d drop_count", i), {24'd0, d_dc}, {24'd0, vecs[i].dc});
`endif
    end

    // 50 edges two cycles apart -> 49 results of 2
    step(0,1,1);
    for (int k = 0; k < 50; k++) begin
      step(1,1,0);
      check("toggle valid", {31'd0, d_valid}, {31'd0, (k > 0)});
      if (k > 0) begin
        check("toggle data", {16'd0, d_data}, 32'd2);
        check("toggle ovf", {31'd0, d_ovf}, 32'd0);
      end
      step(0,1,0);
      check("toggle valid low", {31'd0, d_valid}, 32'd0);
    end
    check("toggle drop", {31'd0, d_drop}, 32'd0);

    // WIDTH=4 overflow: second edge 20 cycles later, then 3 cycles later
    step(0,1,1);
    step(1,1,0);
    for (int i = 0; i < 19; i++) step(0,1,0);
    check("w4 valid before", {31'd0, w_valid}, 32'd0);
    step(1,1,0);
    check("w4 ovf valid", {31'd0, w_valid}, 32'd1);
    check("w4 ovf data", {28'd0, w_data}, 32'd15);
    check("w4 ovf flag", {31'd0, w_ovf}, 32'd1);
    step(0,1,0);
    step(0,1,0);
    step(1,1,0);
    check("w4 next valid", {31'd0, w_valid}, 32'd1);
    check("w4 next data", {28'd0, w_data}, 32'd3);
    check("w4 next ovf", {31'd0, w_ovf}, 32'd0);

    // MIN_PERIOD=3: edges at 0,1,4,7 -> edge at 1 ignored, results 4 then 3
    step(0,1,1);
    step(1,1,0);
    step(1,1,0);
    check("min edge1 ignored", {31'd0, m_valid}, 32'd0);
    step(0,1,0);
    step(0,1,0);
    check("min no result yet", {31'd0, m_valid}, 32'd0);
    step(1,1,0);
    check("min valid", {31'd0, m_valid}, 32'd1);
    check("min data", {16'd0, m_data}, 32'd4);
    step(0,1,0);
    check("min valid falls", {31'd0, m_valid}, 32'd0);
    step(0,1,0);
    step(1,1,0);
    check("min boundary valid", {31'd0, m_valid}, 32'd1);
    check("min boundary data", {16'd0, m_data}, 32'd3);
    check("min drop", {31'd0, m_drop}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
